// File: rtl/wormhole_port_allocator_pkg.sv
// Shared definitions for the wormhole port allocator: state encoding and width helpers.
// The optional lock watchdog in the top level is enabled by defining ARB_LOCK_WATCHDOG_EN.
package wormhole_port_allocator_pkg;

    localparam logic STATE_IDLE_ENC   = 1'b0;
    localparam logic STATE_LOCKED_ENC = 1'b1;

    typedef enum logic {
        ST_IDLE   = STATE_IDLE_ENC,
        ST_LOCKED = STATE_LOCKED_ENC
    } alloc_state_e;

    // Ceiling log2 with a floor of 1 so a field is never zero bits wide.
    function automatic int log2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << r) < value) r = r + 1;
        end
        if (r == 0) r = 1;
        return r;
    endfunction

    function automatic int credit_width(input int depth);
        return log2(depth + 1);
    endfunction

endpackage

// File: rtl/wormhole_port_allocator_rr_bcd_picker.sv
// Combinational round-robin picker: first set request at or above pointer, cyclically,
// returned as a binary index.
module rr_bcd_picker #(
    parameter int ARBITER_WIDTH     = 4,
    parameter int ARBITER_BCD_WIDTH = 2
) (
    input  logic [ARBITER_WIDTH-1:0]     request,
    input  logic [ARBITER_BCD_WIDTH-1:0] pointer,
    output logic [ARBITER_BCD_WIDTH-1:0] sel,
    output logic                         any
);

    int  idx;
    logic found;

    always_comb begin
        sel   = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < ARBITER_WIDTH; k++) begin
            idx = (int'(pointer) + k) % ARBITER_WIDTH;
            if (!found && request[idx]) begin
                found = 1'b1;
                sel   = ARBITER_BCD_WIDTH'(idx);
            end
        end
        any = |request;
    end

endmodule

// File: rtl/wormhole_port_allocator.sv
// Output-port allocator with wormhole locking, downstream credit gating and packet-boundary
// round robin. Define ARB_LOCK_WATCHDOG_EN to build the sticky lock_error watchdog.
module wormhole_port_allocator
    import wormhole_port_allocator_pkg::*;
#(
    parameter int ARBITER_WIDTH     = 4,
    parameter int ARBITER_BCD_WIDTH = log2(ARBITER_WIDTH),
    parameter int CREDIT_DEPTH      = 4,
    parameter int CREDIT_WIDTH      = credit_width(CREDIT_DEPTH),
    parameter int LOCK_TIMEOUT      = 256
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [ARBITER_WIDTH-1:0]     request,
    input  logic [ARBITER_WIDTH-1:0]     tail_flit,
    input  logic                         credit_in,
    output logic [ARBITER_BCD_WIDTH-1:0] grant,
    output logic                         any_grant,
    output logic                         locked,
    output logic [CREDIT_WIDTH-1:0]      credit_count,
    output logic                         lock_error
);

    localparam logic [CREDIT_WIDTH-1:0]      CREDIT_MAX = CREDIT_WIDTH'(CREDIT_DEPTH);
    localparam logic [ARBITER_BCD_WIDTH-1:0] LAST_IDX   = ARBITER_BCD_WIDTH'(ARBITER_WIDTH - 1);

    alloc_state_e                 state_q, state_d;
    logic [ARBITER_BCD_WIDTH-1:0] ptr_q, ptr_d;
    logic [ARBITER_BCD_WIDTH-1:0] owner_q, owner_d;
    logic [CREDIT_WIDTH-1:0]      credit_q, credit_d;

    logic [ARBITER_BCD_WIDTH-1:0] sel;
    logic                         pick_any;
    logic                         credit_ok;
    logic                         xfer;
    logic                         xfer_tail;
    logic [ARBITER_BCD_WIDTH-1:0] cur;

    rr_bcd_picker #(
        .ARBITER_WIDTH    (ARBITER_WIDTH),
        .ARBITER_BCD_WIDTH(ARBITER_BCD_WIDTH)
    ) u_picker (
        .request(request),
        .pointer(ptr_q),
        .sel    (sel),
        .any    (pick_any)
    );

    always_comb begin
        credit_ok = (credit_q != '0);
        xfer      = 1'b0;
        xfer_tail = 1'b0;
        cur       = owner_q;
        if (state_q == ST_IDLE) begin
            xfer = pick_any && credit_ok;
            if (xfer) begin
                cur       = sel;
                xfer_tail = tail_flit[sel];
            end
        end else begin
            xfer      = request[owner_q] && credit_ok;
            xfer_tail = tail_flit[owner_q];
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        if (xfer) begin
            if (xfer_tail) begin
                state_d = ST_IDLE;
                // Explicit wrap so non-power-of-2 widths never land on an unused code.
                ptr_d   = (cur == LAST_IDX) ? '0 : cur + 1'b1;
            end else if (state_q == ST_IDLE) begin
                state_d = ST_LOCKED;
                owner_d = sel;
            end
        end

        credit_d = credit_q;
        if (xfer && !credit_in) begin
            credit_d = credit_q - 1'b1;
        end else if (!xfer && credit_in && credit_q != CREDIT_MAX) begin
            credit_d = credit_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            ptr_q    <= '0;
            owner_q  <= '0;
            credit_q <= CREDIT_MAX;
        end else begin
            state_q  <= state_d;
            ptr_q    <= ptr_d;
            owner_q  <= owner_d;
            credit_q <= credit_d;
        end
    end

    assign grant        = cur;
    assign any_grant    = xfer;
    assign locked       = (state_q == ST_LOCKED);
    assign credit_count = credit_q;

`ifdef ARB_LOCK_WATCHDOG_EN
    localparam int WD_WIDTH = log2(LOCK_TIMEOUT + 1);
    localparam logic [WD_WIDTH-1:0] WD_LIMIT = WD_WIDTH'(LOCK_TIMEOUT);

    logic [WD_WIDTH-1:0] wd_cnt_q, wd_cnt_d;
    logic                lock_error_q, lock_error_d;

    always_comb begin
        wd_cnt_d = wd_cnt_q;
        if (state_q != ST_LOCKED || xfer) begin
            wd_cnt_d = '0;
        end else if (wd_cnt_q != WD_LIMIT) begin
            wd_cnt_d = wd_cnt_q + 1'b1;
        end
        lock_error_d = lock_error_q || (wd_cnt_d == WD_LIMIT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wd_cnt_q     <= '0;
            lock_error_q <= 1'b0;
        end else begin
            wd_cnt_q     <= wd_cnt_d;
            lock_error_q <= lock_error_d;
        end
    end

    assign lock_error = lock_error_q;
`else
    assign lock_error = 1'b0;
`endif

endmodule

// File: tb/tb_wormhole_port_allocator.sv
// Directed bench for wormhole_port_allocator: a 4-wide instance and a 5-wide instance
// share clock and reset.
module tb_wormhole_port_allocator;

    logic       clk;
    logic       reset;
    logic [3:0] req_a, tail_a;
    logic       cin_a;
    logic [1:0] grant_a;
    logic       any_a, locked_a, err_a;
    logic [2:0] credit_a;

    logic [4:0] req_b, tail_b;
    logic       cin_b;
    logic [2:0] grant_b;
    logic       any_b, locked_b, err_b;
    logic [2:0] credit_b;

    int n_cmp;
    int n_fail;

`ifdef ARB_LOCK_WATCHDOG_EN
    localparam logic WD_ON = 1'b1;
`else
    localparam logic WD_ON = 1'b0;
`endif

    wormhole_port_allocator #(
        .ARBITER_WIDTH(4), .CREDIT_DEPTH(4), .LOCK_TIMEOUT(8)
    ) dut_a (
        .clk(clk), .reset(reset), .request(req_a), .tail_flit(tail_a), .credit_in(cin_a),
        .grant(grant_a), .any_grant(any_a), .locked(locked_a), .credit_count(credit_a),
        .lock_error(err_a)
    );

    wormhole_port_allocator #(
        .ARBITER_WIDTH(5), .CREDIT_DEPTH(4), .LOCK_TIMEOUT(8)
    ) dut_b (
        .clk(clk), .reset(reset), .request(req_b), .tail_flit(tail_b), .credit_in(cin_b),
        .grant(grant_b), .any_grant(any_b), .locked(locked_b), .credit_count(credit_b),
        .lock_error(err_b)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task step();
        @(posedge clk);
        #1;
    endtask

    task apply_reset();
        req_a = '0; tail_a = '0; cin_a = 1'b0;
        req_b = '0; tail_b = '0; cin_b = 1'b0;
        reset = 1'b1;
        #1;
        step();
        reset = 1'b0;
    endtask

    // drivers
    task drive_a(input logic [3:0] r, input logic [3:0] t, input logic c);
        req_a = r; tail_a = t; cin_a = c;
        #1;
    endtask

    task drive_b(input logic [4:0] r, input logic [4:0] t, input logic c);
        req_b = r; tail_b = t; cin_b = c;
        #1;
    endtask

    task test_reset();
        reset = 1'b1;
        #1;
        n_cmp++; if (grant_a !== 2'd0) begin n_fail++; $display("FAIL reset_grant: got %0d want 0", grant_a); end
        n_cmp++; if (any_a !== 1'b0) begin n_fail++; $display("FAIL reset_any: got %b want 0", any_a); end
        n_cmp++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL reset_locked: got %b want 0", locked_a); end
        n_cmp++; if (credit_a !== 3'd4) begin n_fail++; $display("FAIL reset_credit: got %0d want 4", credit_a); end
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL reset_lock_error: got %b want 0", err_a); end
        apply_reset();
    endtask

    task test_single_flit();
        apply_reset();
        drive_a(4'b0110, 4'b0110, 1'b0);
        n_cmp++; if (grant_a !== 2'd1) begin n_fail++; $display("FAIL sf_grant1: got %0d want 1", grant_a); end
        n_cmp++; if (any_a !== 1'b1) begin n_fail++; $display("FAIL sf_any1: got %b want 1", any_a); end
        step();
        n_cmp++; if (credit_a !== 3'd3) begin n_fail++; $display("FAIL sf_credit: got %0d want 3", credit_a); end
        n_cmp++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL sf_locked: got %b want 0", locked_a); end
        drive_a(4'b0110, 4'b0110, 1'b0);
        n_cmp++; if (grant_a !== 2'd2) begin n_fail++; $display("FAIL sf_grant2: got %0d want 2", grant_a); end
        step();
    endtask

    task test_wormhole();
        apply_reset();
        drive_a(4'b1111, 4'b0000, 1'b1);
        n_cmp++; if (grant_a !== 2'd0) begin n_fail++; $display("FAIL wh_head_grant: got %0d want 0", grant_a); end
        step();
        n_cmp++; if (locked_a !== 1'b1) begin n_fail++; $display("FAIL wh_locked: got %b want 1", locked_a); end
        for (int c = 0; c < 2; c++) begin
            drive_a(4'b1111, 4'b0000, 1'b1);
            n_cmp++; if (grant_a !== 2'd0 || any_a !== 1'b1) begin n_fail++; $display("FAIL wh_body%0d: got grant %0d any %b want 0 1", c, grant_a, any_a); end
            step();
        end
        drive_a(4'b1110, 4'b0000, 1'b1);
        n_cmp++; if (grant_a !== 2'd0 || any_a !== 1'b0) begin n_fail++; $display("FAIL wh_bubble: got grant %0d any %b want 0 0", grant_a, any_a); end
        step();
        n_cmp++; if (locked_a !== 1'b1) begin n_fail++; $display("FAIL wh_bubble_lock: got %b want 1", locked_a); end
        drive_a(4'b1111, 4'b0001, 1'b1);
        n_cmp++; if (grant_a !== 2'd0 || any_a !== 1'b1) begin n_fail++; $display("FAIL wh_tail: got grant %0d any %b want 0 1", grant_a, any_a); end
        step();
        n_cmp++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL wh_unlock: got %b want 0", locked_a); end
        drive_a(4'b1111, 4'b1111, 1'b1);
        n_cmp++; if (grant_a !== 2'd1) begin n_fail++; $display("FAIL wh_next_grant: got %0d want 1", grant_a); end
        step();
        n_cmp++; if (credit_a !== 3'd4) begin n_fail++; $display("FAIL wh_credit: got %0d want 4", credit_a); end
    endtask

    task test_credit_exhaust();
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            drive_a(4'b0001, 4'b0001, 1'b0);
            n_cmp++; if (any_a !== 1'b1) begin n_fail++; $display("FAIL ce_any%0d: got %b want 1", c, any_a); end
            step();
        end
        n_cmp++; if (credit_a !== 3'd0) begin n_fail++; $display("FAIL ce_zero: got %0d want 0", credit_a); end
        drive_a(4'b0001, 4'b0001, 1'b1);
        n_cmp++; if (any_a !== 1'b0) begin n_fail++; $display("FAIL ce_blocked: got %b want 0", any_a); end
        step();
        n_cmp++; if (credit_a !== 3'd1) begin n_fail++; $display("FAIL ce_return: got %0d want 1", credit_a); end
        drive_a(4'b0001, 4'b0001, 1'b0);
        n_cmp++; if (any_a !== 1'b1) begin n_fail++; $display("FAIL ce_resume: got %b want 1", any_a); end
        step();
        n_cmp++; if (credit_a !== 3'd0) begin n_fail++; $display("FAIL ce_spent: got %0d want 0", credit_a); end
    endtask

    task test_credit_saturate();
        apply_reset();
        drive_a(4'b0000, 4'b0000, 1'b1);
        step();
        n_cmp++; if (credit_a !== 3'd4) begin n_fail++; $display("FAIL cs_sat: got %0d want 4", credit_a); end
        for (int c = 0; c < 2; c++) begin
            drive_a(4'b0001, 4'b0001, 1'b0);
            step();
        end
        n_cmp++; if (credit_a !== 3'd2) begin n_fail++; $display("FAIL cs_two: got %0d want 2", credit_a); end
        drive_a(4'b0001, 4'b0001, 1'b1);
        n_cmp++; if (any_a !== 1'b1) begin n_fail++; $display("FAIL cs_any: got %b want 1", any_a); end
        step();
        n_cmp++; if (credit_a !== 3'd2) begin n_fail++; $display("FAIL cs_both: got %0d want 2", credit_a); end
    endtask

    task test_wrap5();
        logic [4:0] one_hot;
        apply_reset();
        for (int c = 0; c < 4; c++) begin
            one_hot = 5'b00001 << c;
            drive_b(one_hot, one_hot, 1'b1);
            n_cmp++; if (grant_b !== 3'(c)) begin n_fail++; $display("FAIL w5_walk%0d: got %0d want %0d", c, grant_b, c); end
            step();
        end
        drive_b(5'b10001, 5'b10001, 1'b1);
        n_cmp++; if (grant_b !== 3'd4) begin n_fail++; $display("FAIL w5_grant4: got %0d want 4", grant_b); end
        step();
        drive_b(5'b10001, 5'b10001, 1'b1);
        n_cmp++; if (grant_b !== 3'd0) begin n_fail++; $display("FAIL w5_wrap: got %0d want 0", grant_b); end
        step();
        n_cmp++; if (credit_b !== 3'd4) begin n_fail++; $display("FAIL w5_credit: got %0d want 4", credit_b); end
        drive_b(5'b00000, 5'b00000, 1'b0);
    endtask

    task test_reset_mid_packet();
        apply_reset();
        drive_a(4'b1111, 4'b0000, 1'b0);
        step();
        n_cmp++; if (locked_a !== 1'b1 || credit_a !== 3'd3) begin n_fail++; $display("FAIL rm_pre: got locked %b credit %0d want 1 3", locked_a, credit_a); end
        #2;
        reset = 1'b1;
        #1;
        n_cmp++; if (locked_a !== 1'b0) begin n_fail++; $display("FAIL rm_locked: got %b want 0", locked_a); end
        n_cmp++; if (credit_a !== 3'd4) begin n_fail++; $display("FAIL rm_credit: got %0d want 4", credit_a); end
        step();
        reset = 1'b0;
        drive_a(4'b1111, 4'b1111, 1'b0);
        n_cmp++; if (grant_a !== 2'd0) begin n_fail++; $display("FAIL rm_pointer: got %0d want 0", grant_a); end
        step();
    endtask

    task test_watchdog();
        logic exp_err;
        apply_reset();
        drive_a(4'b0100, 4'b0000, 1'b0);
        n_cmp++; if (grant_a !== 2'd2) begin n_fail++; $display("FAIL wd_head: got %0d want 2", grant_a); end
        step();
        for (int c = 1; c <= 11; c++) begin
            drive_a(4'b1011, 4'b0000, 1'b0);
            n_cmp++; if (any_a !== 1'b0 || grant_a !== 2'd2) begin n_fail++; $display("FAIL wd_stall%0d: got any %b grant %0d want 0 2", c, any_a, grant_a); end
            step();
            exp_err = WD_ON && (c >= 8);
            n_cmp++; if (err_a !== exp_err) begin n_fail++; $display("FAIL wd_err%0d: got %b want %b", c, err_a, exp_err); end
        end
        drive_a(4'b0100, 4'b0100, 1'b0);
        step();
        n_cmp++; if (locked_a !== 1'b0 || err_a !== WD_ON) begin n_fail++; $display("FAIL wd_sticky: got locked %b err %b want 0 %b", locked_a, err_a, WD_ON); end
        apply_reset();
        n_cmp++; if (err_a !== 1'b0) begin n_fail++; $display("FAIL wd_clear: got %b want 0", err_a); end
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        reset  = 1'b0;
        req_a = '0; tail_a = '0; cin_a = 1'b0;
        req_b = '0; tail_b = '0; cin_b = 1'b0;
        #2;
        test_reset();
        test_single_flit();
        test_wormhole();
        test_credit_exhaust();
        test_credit_saturate();
        test_wrap5();
        test_reset_mid_packet();
        test_watchdog();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
